condicionador_botoes: RTL and testbench
=======================================

CONDICIONADOR_BOTOES -- requirements
Module: condicionador_botoes

Interface
REQ-001 Parameter N_DEB, default 50000, debounce window in clock cycles (1 ms at 50 MHz), legal range 2..2^20.
REQ-002 clock  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 botoes_raw  input  4  raw push-button levels, 1 = pressed, asynchronous to clock.
REQ-005 habilita  input  1  1 = play pulses may be emitted; 0 = pulses suppressed.
REQ-006 botoes  output  4  debounced button levels, fed to the game circuit's botoes input.
REQ-007 jogada_pulso  output  1  single-cycle strobe marking one accepted press.
REQ-008 jogada_valor  output  4  one-hot code of the last accepted press; held until the next accepted press.
REQ-009 multiplo  output  1  high while a rejected multi-button press is held.
REQ-010 db_estado  output  4  FSM state code, for a hexa7seg display.

Function
REQ-011 botoes_raw SHALL pass through a 2-flop synchronizer; the FSM uses only the second stage (sinc).
REQ-012 States and codes: OCIOSO=0, FILTRA_PRESS=1, EMITE=2, SEGURA=3, FILTRA_SOLTA=4, ERRO_MULTI=5; codes 6-15 unused and SHALL go to OCIOSO.
REQ-013 OCIOSO: if sinc!=0, capture candidato<=sinc, clear counter, go to FILTRA_PRESS; otherwise stay.
REQ-014 FILTRA_PRESS, sinc==0: go to OCIOSO.
REQ-015 FILTRA_PRESS, sinc nonzero but different from candidato: recapture candidato, clear counter, stay.
REQ-016 FILTRA_PRESS, sinc==candidato: increment counter; on the edge where counter==N_DEB-1, go to EMITE if candidato is one-hot, else go to ERRO_MULTI.
REQ-017 EMITE lasts exactly one cycle and then goes to SEGURA. During EMITE:
  - botoes=candidato;
  - jogada_valor<=candidato;
  - jogada_pulso=habilita.
REQ-018 With habilita=0 in EMITE, the pulse is suppressed and jogada_valor is not updated; the FSM still proceeds to SEGURA.
REQ-019 SEGURA: botoes holds candidato. Extra or changed buttons are ignored. When sinc==0, clear counter and go to FILTRA_SOLTA.
REQ-020 FILTRA_SOLTA: if sinc!=0, return to SEGURA (bounce). Otherwise increment counter; at counter==N_DEB-1 go to OCIOSO and clear botoes.
REQ-021 ERRO_MULTI: multiplo=1, botoes=0, no pulse. When sinc==0, clear counter and go to FILTRA_SOLTA.
REQ-022 Latency, with the edge that first samples a stable press as edge 0: the FSM enters EMITE on edge N_DEB+2, and jogada_pulso is high for the following cycle only.
REQ-023 At most one jogada_pulso per press/release cycle, regardless of hold length.
REQ-024 Counter width SHALL be $clog2(N_DEB); it never wraps because it is cleared on every state entry.
REQ-025 All outputs SHALL be registered or decoded from registered state only; no combinational path from botoes_raw to any output.

Reset
REQ-026 When reset=0, all of the following SHALL clear immediately, independent of clock:
  - FSM goes to OCIOSO;
  - synchronizer, counter and candidato clear to 0;
  - botoes, jogada_valor, jogada_pulso and multiplo are 0;
  - db_estado is 0.
REQ-027 Reset asserted mid-press SHALL discard the press. After release of reset, a button still held SHALL be re-filtered from OCIOSO and SHALL produce one pulse after the full REQ-022 latency.

Verification (N_DEB=4)
REQ-028 Clean press: raw=0010 held 20 cycles, then 0 for 20 cycles, habilita=1 -> exactly one pulse at edge 6, jogada_valor=0010, botoes=0010 until 4 cycles after sinc returns to 0.
REQ-029 Bounce: raw toggles 0010/0000 every cycle for 6 cycles, then 0010 stable -> no pulse during the bouncing, one pulse 6 edges after stable.
REQ-030 Multi: raw=0101 held 15 cycles -> ERRO_MULTI (db_estado=5), multiplo=1, no pulse, jogada_valor unchanged; after release, back to OCIOSO.
REQ-031 Disabled: habilita=0, raw=1000 held -> FSM passes through EMITE, no pulse, jogada_valor stays 0000.
REQ-032 Reset mid-hold: reset=0 for 1 cycle while in SEGURA with raw=0001 still held -> all outputs 0 at once, then a second pulse 6 edges after reset is released.
REQ-033 Release bounce: in SEGURA, raw goes 0, then 0001 at FILTRA_SOLTA cycle 2 -> returns to SEGURA, no new pulse.

Source files
------------

// File: rtl/condicionador_botoes.sv
// Push-button conditioner: synchronise, debounce and turn each single-button press into one play strobe.
// Latency: a stable press reaches EMITE on edge N_DEB+2 after it is first sampled; strobe lasts one cycle.
// Backpressure: none; habilita only gates the strobe and the jogada_valor update, the FSM never stalls.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   botoes_raw   raw button levels (1 = pressed), asynchronous to clock
//   habilita     1 = play strobes allowed
//   botoes       debounced levels of the accepted button (0 while idle or in a multi-press)
//   jogada_pulso one-cycle strobe per accepted press
//   jogada_valor one-hot code of the last accepted press, held until the next one
//   multiplo     high while a rejected multi-button press is held
//   db_estado    FSM state code for a 7-segment debug display
module condicionador_botoes #(
  parameter int N_DEB = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes_raw,
  input  logic       habilita,
  output logic [3:0] botoes,
  output logic       jogada_pulso,
  output logic [3:0] jogada_valor,
  output logic       multiplo,
  output logic [3:0] db_estado
);

  localparam int            CW      = (N_DEB > 1) ? $clog2(N_DEB) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(N_DEB - 1);

  typedef enum logic [3:0] {
    OCIOSO       = 4'd0,
    FILTRA_PRESS = 4'd1,
    EMITE        = 4'd2,
    SEGURA       = 4'd3,
    FILTRA_SOLTA = 4'd4,
    ERRO_MULTI   = 4'd5
  } estado_t;

  logic [3:0]    sinc1_q;
  logic [3:0]    sinc_q;
  estado_t       state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    cand_q;
  logic [3:0]    botoes_q;
  logic          pulso_q;
  logic [3:0]    valor_q;
  logic          multi_q;
  logic          cand_one_hot;

  // Two-flop synchroniser; only the second stage is ever looked at.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sinc1_q <= 4'd0;
      sinc_q  <= 4'd0;
    end else begin
      sinc1_q <= botoes_raw;
      sinc_q  <= sinc1_q;
    end
  end

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  assign cand_one_hot = (cand_q != 4'd0) && ((cand_q & (cand_q - 4'd1)) == 4'd0);

  // Outputs are loaded on the edge that enters EMITE, so the strobe and the new
  // jogada_valor are visible together during the single EMITE cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= OCIOSO;
      cnt_q    <= '0;
      cand_q   <= 4'd0;
      botoes_q <= 4'd0;
      pulso_q  <= 1'b0;
      valor_q  <= 4'd0;
      multi_q  <= 1'b0;
    end else begin
      pulso_q <= 1'b0;
      case (state_q)
        OCIOSO: begin
          if (sinc_q != 4'd0) begin
            cand_q  <= sinc_q;
            cnt_q   <= '0;
            state_q <= FILTRA_PRESS;
          end
        end
        FILTRA_PRESS: begin
          if (sinc_q == 4'd0) begin
            state_q <= OCIOSO;
          end else if (sinc_q != cand_q) begin
            // Pattern still settling: restart the window on the new pattern.
            cand_q <= sinc_q;
            cnt_q  <= '0;
          end else if (cnt_q == CNT_MAX) begin
            if (cand_one_hot) begin
              state_q  <= EMITE;
              botoes_q <= cand_q;
              pulso_q  <= habilita;
              if (habilita) valor_q <= cand_q;
            end else begin
              state_q  <= ERRO_MULTI;
              botoes_q <= 4'd0;
              multi_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        EMITE: begin
          state_q <= SEGURA;
        end
        SEGURA: begin
          // Extra or changed buttons while held are ignored; only full release matters.
          if (sinc_q == 4'd0) begin
            cnt_q   <= '0;
            state_q <= FILTRA_SOLTA;
          end
        end
        FILTRA_SOLTA: begin
          if (sinc_q != 4'd0) begin
            state_q <= SEGURA;
          end else if (cnt_q == CNT_MAX) begin
            state_q  <= OCIOSO;
            botoes_q <= 4'd0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ERRO_MULTI: begin
          if (sinc_q == 4'd0) begin
            cnt_q   <= '0;
            multi_q <= 1'b0;
            state_q <= FILTRA_SOLTA;
          end
        end
        default: begin
          state_q  <= OCIOSO;
          botoes_q <= 4'd0;
          multi_q  <= 1'b0;
        end
      endcase
    end
  end

  assign botoes       = botoes_q;
  assign jogada_pulso = pulso_q;
  assign jogada_valor = valor_q;
  assign multiplo     = multi_q;
  assign db_estado    = state_q;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Bench for condicionador_botoes with N_DEB=4: table of press/release cases plus hand sequences.
// Expected strobes are queued when a press is driven and matched when the DUT strobes.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_condicionador_botoes;

  logic       clock;
  logic       reset;
  logic [3:0] botoes_raw;
  logic       habilita;
  logic [3:0] botoes;
  logic       jogada_pulso;
  logic [3:0] jogada_valor;
  logic       multiplo;
  logic [3:0] db_estado;

  condicionador_botoes #(.N_DEB(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .botoes_raw   (botoes_raw),
    .habilita     (habilita),
    .botoes       (botoes),
    .jogada_pulso (jogada_pulso),
    .jogada_valor (jogada_valor),
    .multiplo     (multiplo),
    .db_estado    (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } exp_t;

  typedef struct {
    logic [3:0] raw;
    logic       hab;
    int         hold;
    logic       pulse;
    logic [3:0] st;
    logic [3:0] bot;
    logic       multi;
    logic [3:0] valor;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[6];
  int   checks;
  int   errors;
  int   cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle; any strobe seen here must match the head of the queue.
  task automatic tick();
    exp_t e;
    @(negedge clock);
    cyc++;
    if (jogada_pulso !== 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got pulso=%b valor=%b at cycle %0d expected no pulse",
                 jogada_pulso, jogada_valor, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_valor", jogada_valor, e.val);
      end
    end
  endtask

  // Press is driven now, so edge 0 is the next rising edge and EMITE is
  // visible at the sample taken seven cycles from now.
  task automatic expect_pulse(input logic [3:0] val);
    exp_t e;
    e.cyc = cyc + 7;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic check_pending(input string name);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_case(input vec_t v);
    botoes_raw = v.raw;
    habilita   = v.hab;
    if (v.pulse) expect_pulse(v.raw);
    repeat (v.hold) tick();
    chk("hold_state", db_estado, v.st);
    chk("hold_botoes", botoes, v.bot);
    chk("hold_multiplo", multiplo, v.multi);
    botoes_raw = 4'b0000;
    // Release: FILTRA_SOLTA entered on edge 2, back to OCIOSO on edge 6.
    repeat (6) tick();
    chk("rel_state_filtra", db_estado, 4'd4);
    chk("rel_botoes_held", botoes, v.bot);
    tick();
    chk("rel_state_idle", db_estado, 4'd0);
    chk("rel_botoes_clear", botoes, 4'd0);
    repeat (10) tick();
    chk("case_valor", jogada_valor, v.valor);
    chk("case_multiplo", multiplo, 1'b0);
    check_pending("case_pending");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;

    //          raw      hab   hold pulse st    bot      multi valor
    tbl[0] = '{4'b1000, 1'b0, 20,  1'b0, 4'd3, 4'b1000, 1'b0, 4'b0000};
    tbl[1] = '{4'b0010, 1'b1, 20,  1'b1, 4'd3, 4'b0010, 1'b0, 4'b0010};
    tbl[2] = '{4'b0101, 1'b1, 15,  1'b0, 4'd5, 4'b0000, 1'b1, 4'b0010};
    tbl[3] = '{4'b0001, 1'b1, 12,  1'b1, 4'd3, 4'b0001, 1'b0, 4'b0001};
    tbl[4] = '{4'b1111, 1'b1, 12,  1'b0, 4'd5, 4'b0000, 1'b1, 4'b0001};
    tbl[5] = '{4'b0100, 1'b0, 12,  1'b0, 4'd3, 4'b0100, 1'b0, 4'b0001};

    reset      = 1'b0;
    botoes_raw = 4'b0000;
    habilita   = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_botoes", botoes, 4'd0);
    chk("rst_pulso", jogada_pulso, 1'b0);
    chk("rst_valor", jogada_valor, 4'd0);
    chk("rst_multiplo", multiplo, 1'b0);
    chk("rst_state", db_estado, 4'd0);
    reset = 1'b1;
    repeat (3) tick();
    chk("idle_state", db_estado, 4'd0);

    for (int i = 0; i < 6; i++) run_case(tbl[i]);

    // Bouncing press: only the stable tail is filtered.
    habilita = 1'b1;
    for (int i = 0; i < 6; i++) begin
      botoes_raw = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      tick();
    end
    botoes_raw = 4'b0010;
    expect_pulse(4'b0010);
    repeat (14) tick();
    chk("bounce_state", db_estado, 4'd3);
    chk("bounce_valor", jogada_valor, 4'b0010);
    botoes_raw = 4'b0000;
    repeat (20) tick();
    check_pending("bounce_pending");

    // Reset while held: everything clears at once, then the held button is re-filtered.
    botoes_raw = 4'b0001;
    expect_pulse(4'b0001);
    repeat (12) tick();
    chk("mid_state_hold", db_estado, 4'd3);
    reset = 1'b0;
    #1;
    chk("mid_rst_botoes", botoes, 4'd0);
    chk("mid_rst_valor", jogada_valor, 4'd0);
    chk("mid_rst_pulso", jogada_pulso, 1'b0);
    chk("mid_rst_state", db_estado, 4'd0);
    tick();
    reset = 1'b1;
    expect_pulse(4'b0001);
    repeat (12) tick();
    chk("mid_state_again", db_estado, 4'd3);
    chk("mid_valor_again", jogada_valor, 4'b0001);
    botoes_raw = 4'b0000;
    repeat (20) tick();
    check_pending("mid_pending");

    // Release bounce: button returns during FILTRA_SOLTA, no new strobe.
    botoes_raw = 4'b0100;
    expect_pulse(4'b0100);
    repeat (12) tick();
    botoes_raw = 4'b0000;
    repeat (3) tick();
    botoes_raw = 4'b0001;
    tick();
    chk("relb_state_filtra", db_estado, 4'd4);
    repeat (2) tick();
    chk("relb_state_segura", db_estado, 4'd3);
    chk("relb_botoes", botoes, 4'b0100);
    repeat (10) tick();
    botoes_raw = 4'b0000;
    repeat (20) tick();
    chk("relb_state_idle", db_estado, 4'd0);
    chk("relb_valor", jogada_valor, 4'b0100);
    check_pending("relb_pending");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
